// File: rtl/hermes_ni_rx.sv
// rtl/hermes_ni_rx.sv - Hermes NI receive endpoint: credit link in, framed flit stream to the PE
// Optional packet counter output pkt_count_o enabled by defining HERMES_NI_RX_STATS_EN.
module hermes_ni_rx #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 pe_valid_o,
  input  logic                 pe_ready_i,
  output logic [FLIT_SIZE-1:0] pe_data_o,
  output logic                 pe_sop_o,
  output logic                 pe_eop_o
`ifdef HERMES_NI_RX_STATS_EN
  ,
  output logic [31:0]          pkt_count_o
`endif
);

  localparam int AW = $clog2(BUFFER_SIZE);

  typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD} state_t;

  state_t                 state;
  logic [FLIT_SIZE-1:0]   payload_cnt;
  logic [FLIT_SIZE+1:0]   mem [BUFFER_SIZE];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [AW:0]            next_count;
  logic                   push;
  logic                   pop;
  logic                   tag_sop;
  logic                   tag_eop;
  logic [FLIT_SIZE+1:0]   head;

  assign push = rx_i && credit_o;
  assign pop  = pe_valid_o && pe_ready_i;

  // Tags depend on where the incoming flit sits in its packet.
  always_comb begin
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    case (state)
      S_HEADER:  tag_sop = 1'b1;
      S_SIZE:    tag_eop = (data_i == '0);
      S_PAYLOAD: tag_eop = (payload_cnt == FLIT_SIZE'(1));
      default:   ;
    endcase
  end

  always_comb begin
    next_count = count;
    if (push) next_count = next_count + (AW+1)'(1);
    if (pop)  next_count = next_count - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_HEADER;
      payload_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      credit_o    <= 1'b0;
    end else begin
      count    <= next_count;
      credit_o <= (next_count < (AW+1)'(BUFFER_SIZE));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        case (state)
          S_HEADER: state <= S_SIZE;
          S_SIZE: begin
            payload_cnt <= data_i;
            state       <= (data_i == '0) ? S_HEADER : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            payload_cnt <= payload_cnt - FLIT_SIZE'(1);
            if (payload_cnt == FLIT_SIZE'(1)) state <= S_HEADER;
          end
          default: state <= S_HEADER;
        endcase
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {tag_sop, tag_eop, data_i};
  end

  assign head       = mem[rd_ptr];
  assign pe_valid_o = (count != '0);
  assign pe_sop_o   = pe_valid_o ? head[FLIT_SIZE+1] : 1'b0;
  assign pe_eop_o   = pe_valid_o ? head[FLIT_SIZE]   : 1'b0;
  assign pe_data_o  = pe_valid_o ? head[FLIT_SIZE-1:0] : '0;

`ifdef HERMES_NI_RX_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              pkt_count_o <= '0;
    else if (push && tag_eop) pkt_count_o <= pkt_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hermes_ni_rx.sv
// tb/tb_hermes_ni_rx.sv - randomized self-checking bench for hermes_ni_rx against a packet-level model
module tb_hermes_ni_rx;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic [31:0] data = '0;
  logic        credit;
  logic        pe_valid;
  logic        pe_ready = 1'b0;
  logic [31:0] pe_data;
  logic        pe_sop;
  logic        pe_eop;
`ifdef HERMES_NI_RX_STATS_EN
  logic [31:0] pkt_count;
  int unsigned m_pkt = 0;
`endif

  int checks = 0;
  int errors = 0;

  flit_t link_q[$];
  flit_t exp_q[$];
  logic  m_credit = 1'b0;
  int    rx_pct = 100;
  int    rdy_pct = 100;

  always #5 clk = ~clk;

  hermes_ni_rx #(.FLIT_SIZE(32), .BUFFER_SIZE(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_i(data), .credit_o(credit),
    .pe_valid_o(pe_valid), .pe_ready_i(pe_ready), .pe_data_o(pe_data),
    .pe_sop_o(pe_sop), .pe_eop_o(pe_eop)
`ifdef HERMES_NI_RX_STATS_EN
    , .pkt_count_o(pkt_count)
`endif
  );

  // A Hermes packet: header, size, then `size` payload flits; the last flit carries eop.
  task automatic add_packet(input logic [31:0] hdr, input int size, input logic fixed,
                            input logic [31:0] p0, input logic [31:0] p1);
    link_q.push_back('{sop: 1'b1, eop: 1'b0, data: hdr});
    link_q.push_back('{sop: 1'b0, eop: (size == 0), data: 32'(size)});
    for (int i = 0; i < size; i++) begin
      logic [31:0] p;
      p = fixed ? ((i == 0) ? p0 : p1) : $urandom;
      link_q.push_back('{sop: 1'b0, eop: (i == size - 1), data: p});
    end
  endtask

  function automatic logic [35:0] exp_out();
    if (exp_q.size() != 0) return {m_credit, 1'b1, exp_q[0]};
    return {m_credit, 35'd0};
  endfunction

  // One clock of the model: link transfers when the credit is up, the PE pops when ready.
  task automatic advance();
    logic acc, pop;
    acc = rx && m_credit;
    pop = pe_ready && (exp_q.size() != 0);
    @(posedge clk); #1;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
`ifdef HERMES_NI_RX_STATS_EN
      if (link_q[0].eop) m_pkt++;
`endif
      exp_q.push_back(link_q.pop_front());
    end
    m_credit = (exp_q.size() < 8);
    if (!rx || acc) begin
      if (link_q.size() != 0 && $urandom_range(0, 99) < rx_pct) begin
        rx = 1'b1; data = link_q[0].data;
      end else begin
        rx = 1'b0; data = $urandom;
      end
    end
    pe_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    link_q.delete(); exp_q.delete();
    m_credit = 1'b0; rx = 1'b0; pe_ready = 1'b0;
`ifdef HERMES_NI_RX_STATS_EN
    m_pkt = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    rst_n = 1'b0; #1;
    got = {credit, pe_valid, pe_sop, pe_eop, pe_data};
    checks++;
    if (got !== 36'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", got); end
    apply_reset();
    checks++;
    if (credit !== 1'b0) begin errors++; $display("FAIL credit_before_edge got %b want 0", credit); end
    advance();
    checks++;
    if (credit !== 1'b1) begin errors++; $display("FAIL credit_after_edge got %b want 1", credit); end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    logic [35:0] got;
    while ((link_q.size() != 0 || exp_q.size() != 0) && guard < 3000) begin
      advance();
      guard++;
      got = {credit, pe_valid, pe_sop, pe_eop, pe_data};
      checks++;
      if (got !== exp_out()) begin
        errors++; $display("FAIL %s cycle %0d got %h want %h", name, guard, got, exp_out());
      end
    end
    checks++;
    if (guard >= 3000) begin errors++; $display("FAIL %s timeout got busy want idle", name); end
  endtask

  task automatic test_single_packet();
    logic [35:0] got;
    rx_pct = 100; rdy_pct = 100; pe_ready = 1'b1;
    add_packet(32'h11, 2, 1'b1, 32'hAAAA0001, 32'hAAAA0002);
    rx = 1'b1; data = link_q[0].data;
    for (int i = 0; i < 6; i++) begin
      advance();
      got = {credit, pe_valid, pe_sop, pe_eop, pe_data};
      checks++;
      if (got !== exp_out()) begin errors++; $display("FAIL single cycle %0d got %h want %h", i, got, exp_out()); end
    end
    checks++;
    if (link_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL single_done got %0d/%0d want 0/0", link_q.size(), exp_q.size());
    end
  endtask

  task automatic test_zero_size();
    rx_pct = 100; rdy_pct = 100;
    add_packet(32'h22, 0, 1'b0, 0, 0);
    add_packet(32'h44, 1, 1'b0, 0, 0);
    drain("zero_size");
  endtask

  task automatic test_full_backpressure();
    int guard = 0;
    rx_pct = 100; rdy_pct = 0; pe_ready = 1'b0;
    add_packet(32'h55, 8, 1'b0, 0, 0);
    while (exp_q.size() < 8 && guard < 50) begin advance(); guard++; end
    checks++;
    if (credit !== 1'b0) begin errors++; $display("FAIL full_credit got %b want 0", credit); end
    repeat (3) advance();
    checks++;
    if (credit !== 1'b0 || link_q.size() != 2 || pe_data !== exp_q[0].data) begin
      errors++; $display("FAIL full_hold credit %b pending %0d want 0 2", credit, link_q.size());
    end
    pe_ready = 1'b1;
    advance();
    checks++;
    if (credit !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", credit); end
    advance();
    checks++;
    if (link_q.size() != 1 || credit !== 1'b0) begin
      errors++; $display("FAIL full_flit9 pending %0d credit %b want 1 0", link_q.size(), credit);
    end
    rdy_pct = 100;
    drain("full_drain");
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    logic [35:0] got;
    rx_pct = 100; rdy_pct = 0; pe_ready = 1'b0;
    add_packet(32'h66, 40, 1'b0, 0, 0);
    while (exp_q.size() < 4 && guard < 50) begin advance(); guard++; end
    rdy_pct = 100; pe_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      advance();
      got = {credit, pe_valid, pe_sop, pe_eop, pe_data};
      checks++;
      if (got !== exp_out() || exp_q.size() != 4) begin
        errors++; $display("FAIL simul cycle %0d got %h want %h", i, got, exp_out());
      end
    end
    drain("simul_drain");
  endtask

  task automatic test_reset_mid_packet();
    logic [35:0] got;
    rx_pct = 100; rdy_pct = 0; pe_ready = 1'b0;
    add_packet(32'h77, 6, 1'b0, 0, 0);
    rx = 1'b1; data = link_q[0].data;
    repeat (5) advance();
    apply_reset();
    got = {credit, pe_valid, pe_sop, pe_eop, pe_data};
    checks++;
    if (got !== 36'd0) begin errors++; $display("FAIL midreset_outputs got %h want 0", got); end
    rdy_pct = 100;
    add_packet(32'h33, 1, 1'b1, 32'hBEEF, 0);
    advance();
    checks++;
    if (credit !== 1'b1 || pe_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release credit %b valid %b want 1 0", credit, pe_valid);
    end
    drain("midreset_packet");
  endtask

  task automatic test_random();
    rx_pct = 70; rdy_pct = 60;
    for (int i = 0; i < 12; i++) add_packet($urandom, $urandom_range(0, 6), 1'b0, 0, 0);
    drain("random");
    rx_pct = 100; rdy_pct = 30;
    for (int i = 0; i < 6; i++) add_packet($urandom, $urandom_range(0, 10), 1'b0, 0, 0);
    drain("random_slowpe");
  endtask

`ifdef HERMES_NI_RX_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++;
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d want 0", pkt_count); end
    rx_pct = 80; rdy_pct = 80;
    add_packet(32'h1, 0, 1'b0, 0, 0);
    add_packet(32'h2, 1, 1'b0, 0, 0);
    add_packet(32'h3, 5, 1'b0, 0, 0);
    drain("stats_traffic");
    checks++;
    if (pkt_count !== 32'd3 || pkt_count !== m_pkt) begin
      errors++; $display("FAIL stats_count got %0d want 3", pkt_count);
    end
    apply_reset();
    checks++;
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL stats_rereset got %0d want 0", pkt_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_zero_size();
    test_full_backpressure();
    test_simultaneous();
    test_reset_mid_packet();
    test_random();
`ifdef HERMES_NI_RX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
